// File: rtl/pm_pkg.sv
// Shared widths, step length and FSM encoding for the path-metric write scheduler.
package pm_pkg;

  localparam int PM_W        = 7;
  localparam int ADDR_W      = 2;
  localparam int ID_W        = 4;
  localparam int STEP_STATES = 4;
  localparam int CNT_W       = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_CLOSE  = 2'd2
  } pm_state_t;

  function automatic logic [PM_W-1:0] sat_sub(input logic [PM_W-1:0] a,
                                              input logic [PM_W-1:0] b);
    return (a > b) ? (a - b) : '0;
  endfunction

endpackage

// File: rtl/pm_sched_if.sv
// Two ACS requester write channels (valid/ready handshake) into the scheduler.
interface pm_sched_if;
  import pm_pkg::*;

  logic              rq0_valid;
  logic              rq0_ready;
  logic [ADDR_W-1:0] rq0_addr;
  logic [PM_W-1:0]   rq0_pm;
  logic              rq0_dec;
  logic [ID_W-1:0]   rq0_id;

  logic              rq1_valid;
  logic              rq1_ready;
  logic [ADDR_W-1:0] rq1_addr;
  logic [PM_W-1:0]   rq1_pm;
  logic              rq1_dec;
  logic [ID_W-1:0]   rq1_id;

  modport master (
    output rq0_valid, rq0_addr, rq0_pm, rq0_dec, rq0_id,
    output rq1_valid, rq1_addr, rq1_pm, rq1_dec, rq1_id,
    input  rq0_ready, rq1_ready
  );

  modport slave (
    input  rq0_valid, rq0_addr, rq0_pm, rq0_dec, rq0_id,
    input  rq1_valid, rq1_addr, rq1_pm, rq1_dec, rq1_id,
    output rq0_ready, rq1_ready
  );

endinterface

// File: rtl/pm_rr_arb.sv
// Two-way round-robin arbiter with one-hot grant; priority flips on every transfer.
module pm_rr_arb (
  input  logic       PM_clk,
  input  logic       PM_rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  logic ptr;  // 1: rq1 wins a tie

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req == 2'b11) gnt = ptr ? 2'b10 : 2'b01;
      else              gnt = req;
    end
  end

  always_ff @(posedge PM_clk or negedge PM_rst) begin
    if (!PM_rst)     ptr <= 1'b0;
    else if (gnt[0]) ptr <= 1'b1;
    else if (gnt[1]) ptr <= 1'b0;
  end

endmodule

// File: rtl/pm_sched.sv
// Path-metric write scheduler: arbitrates two ACS requesters into one PM write port,
// groups writes into 4-state steps and applies per-step metric normalization.
//   state  | meaning
//   IDLE   | waiting for the first write of a step
//   ACTIVE | collecting writes 2..4 of the step
//   CLOSE  | one cycle, no grants, step_done, normalization decision
module pm_sched
  import pm_pkg::*;
#(
  parameter logic [PM_W-1:0] NORM_TH = 7'd64
) (
  input  logic              PM_clk,
  input  logic              PM_rst,
  pm_sched_if.slave         bus,
  output logic              data_en,
  output logic [ADDR_W-1:0] addr_in,
  output logic [PM_W-1:0]   PM_in,
  output logic              dec_in,
  output logic [ID_W-1:0]   data_id,
  output logic              step_done,
  output logic              norm_act,
  output logic              seq_err
);

  pm_state_t              state, state_nxt;
  logic [1:0]             gnt;
  logic                   grant_en, acc, sel;
  logic [ADDR_W-1:0]      w_addr;
  logic [PM_W-1:0]        w_pm;
  logic                   w_dec;
  logic [ID_W-1:0]        w_id;
  logic [STEP_STATES-1:0] a_bit;
  logic [CNT_W-1:0]       wr_cnt;
  logic [STEP_STATES-1:0] addr_seen;
  logic [PM_W-1:0]        step_min, norm_sub;
  logic [ID_W-1:0]        step_id;

  // Gating with PM_rst keeps the readies low while reset is held.
  assign grant_en  = PM_rst && (state != ST_CLOSE);
  assign step_done = (state == ST_CLOSE);

  pm_rr_arb u_arb (
    .PM_clk (PM_clk),
    .PM_rst (PM_rst),
    .req    ({bus.rq1_valid, bus.rq0_valid}),
    .en     (grant_en),
    .gnt    (gnt)
  );

  assign bus.rq0_ready = gnt[0];
  assign bus.rq1_ready = gnt[1];
  assign acc    = |gnt;
  assign sel    = gnt[1];
  assign w_addr = sel ? bus.rq1_addr : bus.rq0_addr;
  assign w_pm   = sel ? bus.rq1_pm   : bus.rq0_pm;
  assign w_dec  = sel ? bus.rq1_dec  : bus.rq0_dec;
  assign w_id   = sel ? bus.rq1_id   : bus.rq0_id;
  assign a_bit  = {{(STEP_STATES-1){1'b0}}, 1'b1} << w_addr;

  always_ff @(posedge PM_clk or negedge PM_rst) begin
    if (!PM_rst) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (acc) state_nxt = ST_ACTIVE;
      ST_ACTIVE: if (acc && (wr_cnt == CNT_W'(STEP_STATES - 1))) state_nxt = ST_CLOSE;
      ST_CLOSE:  state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge PM_clk or negedge PM_rst) begin
    if (!PM_rst) begin
      wr_cnt    <= '0;
      addr_seen <= '0;
      step_min  <= '1;
      step_id   <= '0;
      norm_sub  <= '0;
      norm_act  <= 1'b0;
      seq_err   <= 1'b0;
      data_en   <= 1'b0;
      addr_in   <= '0;
      PM_in     <= '0;
      dec_in    <= 1'b0;
      data_id   <= '0;
    end else begin
      data_en <= acc;
      if (acc) begin
        addr_in <= w_addr;
        PM_in   <= norm_act ? sat_sub(w_pm, norm_sub) : w_pm;
        dec_in  <= w_dec;
        data_id <= w_id;
      end
      case (state)
        ST_IDLE: begin
          if (acc) begin
            step_id   <= w_id;
            wr_cnt    <= CNT_W'(1);
            addr_seen <= a_bit;
            step_min  <= w_pm;
          end
        end
        ST_ACTIVE: begin
          if (acc) begin
            wr_cnt    <= wr_cnt + CNT_W'(1);
            addr_seen <= addr_seen | a_bit;
            if (w_pm < step_min) step_min <= w_pm;
            if ((w_id != step_id) || addr_seen[w_addr]) seq_err <= 1'b1;
          end
        end
        ST_CLOSE: begin
          wr_cnt    <= '0;
          addr_seen <= '0;
          step_min  <= '1;
          if (step_min >= NORM_TH) begin
            norm_sub <= step_min;
            norm_act <= 1'b1;
          end else begin
            norm_sub <= '0;
            norm_act <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
